fnn_argmax_sequencer: RTL and testbench
=======================================

# fnn_argmax_sequencer

Sequential controller for the FNN output layer: walks output neurons 0..NUM_CLASSES-1 one at a time through the shared output-neuron datapath with a start/done handshake, tracks the running maximum score, and presents the winning class index with a valid/ready handshake. It sits between the output-layer neuron datapath and the classification consumer. It replaces a flat 10-way combinational compare with a single 8-bit comparator, and it time-shares one neuron unit.

## Interface
- NUM_CLASSES, 10, number of output neurons to sequence (2..16)
- SCORE_W, 8, unsigned score width
- IDX_W, 4, class index width (must satisfy 2^IDX_W >= NUM_CLASSES)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request a classification run; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- neuron_sel  out  IDX_W  index of neuron currently being evaluated
- neuron_start  out  1  one-cycle pulse launching the neuron datapath on neuron_sel
- neuron_done  in  1  datapath result strobe; honoured only in WAIT
- neuron_score  in  SCORE_W  unsigned score, valid when neuron_done=1
- max  out  IDX_W  winning class index
- max_score  out  SCORE_W  score of winning class
- valid  out  1  result available
- ready  in  1  consumer accepts result

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: when start=1, clear idx to 0 and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: neuron_start=1 for exactly this cycle, with neuron_sel=idx. Go to WAIT.
- WAIT: neuron_sel is held at idx. Stay in WAIT until neuron_done=1. On that cycle:
  - if idx==0 or neuron_score > best_score (strict, unsigned), load best_score<=neuron_score and best_idx<=idx.
  - if idx==NUM_CLASSES-1, copy the post-update best into the max/max_score registers and go to DONE.
  - else idx<=idx+1 and go to ISSUE.
- DONE: valid=1. max and max_score are stable. When valid&&ready, go to IDLE; valid is low from the next cycle.
- Tie rule: the lowest index among equal maxima wins, because the compare is strict.
- Arithmetic: unsigned SCORE_W-bit compare only; no accumulation and no overflow path.
- max/max_score change only on the WAIT→DONE transition. They hold their value through IDLE until the next run completes.
- start while busy=1 is ignored and is not queued.
- neuron_done in IDLE, ISSUE or DONE is ignored.
- neuron_score is don't-care when neuron_done=0.

## Timing
- Reset values: state IDLE, busy 0, neuron_start 0, neuron_sel 0, max 0, max_score 0, valid 0. Internal idx, best_idx and best_score are all 0.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous). The partial result is discarded and no valid is produced.
- Per neuron: 1 ISSUE cycle plus k≥1 WAIT cycles, where k is the cycle count until neuron_done.
- Start sampled at edge 0 with neuron_done returned in the first WAIT cycle:
  - neuron_start pulses at cycles 1,3,5,…,2·NUM_CLASSES-1.
  - valid rises at cycle 2·NUM_CLASSES+1 (cycle 21 for the defaults).
- If ready is already high when valid rises, valid stays high for exactly 1 cycle.
- Back-to-back runs: start asserted on the first IDLE cycle after the handshake gives the next neuron_start one cycle later. The minimum gap between runs is 1 IDLE cycle.
- busy goes high the cycle after start is sampled. It goes low the cycle after the valid&&ready handshake.

## Test plan
- Basic run: scores idx0..9 = 9,7,6,15,13,17,20,7,1,2, done returned 1 cycle after each neuron_start.
  - Required: max=6, max_score=20, valid at cycle 21, exactly 10 neuron_start pulses with neuron_sel 0..9 in order.
- Ties:
  - all scores 5 → max=0, max_score=5.
  - scores with 200 at idx3 and idx8, all others <200 → max=3.
  - single 255 at idx9, all others 254 → max=9, max_score=255.
- Variable latency and stray strobes: done delayed 0..7 random cycles per neuron, plus neuron_done pulses injected in IDLE and DONE.
  - Required: same result as a reference argmax; no extra sel advance; neuron_start never re-pulses while in WAIT.
- Backpressure: ready held low for 5 cycles after valid, with start pulsed during DONE.
  - Required: valid, max and max_score stable throughout; start ignored; IDLE entered 1 cycle after ready rises; no second run begins.
- Reset mid-run: rst pulled low while in WAIT for idx=4, released 2 cycles later.
  - Required: all outputs at reset values during reset and after release, valid never asserted.
  - A following run on the basic-run data gives max=6.
- Back-to-back: two runs with different data (second run winner idx2=99), start held high continuously.
  - Required: second run's first neuron_start is 2 cycles after the first handshake; max updates from 6 to 2 only when the second valid rises.

Source files
------------

// File: rtl/fnn_argmax_sequencer.sv
// Output-layer argmax sequencer: time-shares one neuron datapath across NUM_CLASSES
// neurons and tracks the running maximum with a single strict comparator.
module fnn_argmax_sequencer #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned SCORE_W     = 8,
   parameter int unsigned IDX_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic [IDX_W-1:0]   neuron_sel,
   output logic               neuron_start,
   input  logic               neuron_done,
   input  logic [SCORE_W-1:0] neuron_score,
   output logic [IDX_W-1:0]   max,
   output logic [SCORE_W-1:0] max_score,
   output logic               valid,
   input  logic               ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, best_idx, cand_idx;
   logic [SCORE_W-1:0] best_score, cand_score;
   logic               take, last;

   always_comb begin
      // Strict compare keeps the lowest index on ties; idx 0 always seeds the max.
      take       = (idx == '0) || (neuron_score > best_score);
      cand_idx   = take ? idx : best_idx;
      cand_score = take ? neuron_score : best_score;
      last       = (idx == LAST_IDX);

      state_nxt    = state;
      busy         = (state != IDLE);
      neuron_start = (state == ISSUE);
      valid        = (state == DONE);
      neuron_sel   = idx;

      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (neuron_done) state_nxt = last ? DONE : ISSUE;
         DONE:    if (ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         idx        <= '0;
         best_idx   <= '0;
         best_score <= '0;
         max        <= '0;
         max_score  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) idx <= '0;
            WAIT: begin
               if (neuron_done) begin
                  best_idx   <= cand_idx;
                  best_score <= cand_score;
                  if (last) begin
                     max       <= cand_idx;
                     max_score <= cand_score;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fnn_argmax_sequencer.sv
// Scoreboard bench for fnn_argmax_sequencer: a responder models the neuron datapath,
// a monitor pops expected results when valid rises.
module tb_fnn_argmax_sequencer;

   localparam int NC = 10;
   localparam int SW = 8;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          neuron_done = 1'b0;
   logic [SW-1:0] neuron_score = '0;
   logic          ready = 1'b1;
   logic          busy, neuron_start, valid;
   logic [IW-1:0] neuron_sel, max;
   logic [SW-1:0] max_score;

   fnn_argmax_sequencer #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .neuron_sel(neuron_sel), .neuron_start(neuron_start),
      .neuron_done(neuron_done), .neuron_score(neuron_score),
      .max(max), .max_score(max_score), .valid(valid), .ready(ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int score;
      int vcyc;
   } exp_t;

   exp_t    sbq[$];
   int      n_cmp = 0;
   int      n_bad = 0;
   int      cyc = 0;
   int      sc [NC];
   int      lat [NC];
   int      exp_sel = 0;
   int      npulse = 0;
   int      cd = -1;
   int      cur = 0;
   bit      stray_en = 1'b0;
   logic    valid_q = 1'b0;
   logic    rst_q = 1'b0;
   logic [IW-1:0] max_q = '0;
   logic [SW-1:0] ms_q = '0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Neuron datapath model: returns sc[sel] lat[sel] cycles into WAIT.
   always @(negedge clk) begin
      if (!rst) begin
         cd = -1;
         neuron_done = 1'b0;
      end else begin
         if (cd == 0) begin
            neuron_done  = 1'b1;
            neuron_score = SW'(sc[cur]);
            cd = -1;
         end else begin
            if (cd > 0) cd--;
            neuron_done  = stray_en && (!busy || valid) && ($urandom_range(0, 1) == 1);
            neuron_score = '1;
         end
         if (neuron_start) begin
            chk("start_outside_wait", cd, -1);
            chk("neuron_sel", int'(neuron_sel), exp_sel);
            exp_sel++;
            npulse++;
            cur = (int'(neuron_sel) < NC) ? int'(neuron_sel) : 0;
            cd  = lat[cur];
         end
      end
   end

   // Monitor: pops expected results on valid rise, checks max/max_score stability otherwise.
   always @(negedge clk) begin
      if (rst && rst_q) begin
         if (valid && !valid_q) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_valid: got valid=1, expected no result (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("max", int'(max), e.idx);
               chk("max_score", int'(max_score), e.score);
               chk("pulse_count", npulse, NC);
               if (e.vcyc >= 0) chk("valid_cycle", cyc, e.vcyc);
            end
            exp_sel = 0;
            npulse  = 0;
         end else begin
            chk("max_stable", int'(max), int'(max_q));
            chk("max_score_stable", int'(max_score), int'(ms_q));
         end
      end
      valid_q = valid;
      max_q   = max;
      ms_q    = max_score;
      rst_q   = rst;
   end

   task automatic go(input int eidx, input int escore, input bit timed, input bit push);
      exp_t e;
      @(negedge clk);
      if (push) begin
         e.idx = eidx;
         e.score = escore;
         e.vcyc = timed ? cyc + 21 : -1;
         sbq.push_back(e);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!valid && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!valid) chk({name, "_valid_timeout"}, 0, 1);
   endtask

   task automatic finish_run(input string name);
      wait_valid(name);
      @(negedge clk);
      chk({name, "_idle_after_hs"}, int'(busy), 0);
   endtask

   task automatic zero_lat();
      for (int i = 0; i < NC; i++) lat[i] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      zero_lat();
      sc = '{default: 0};
      #1 rst = 1'b0;
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_nstart", int'(neuron_start), 0);
      chk("rst_sel", int'(neuron_sel), 0);
      chk("rst_max", int'(max), 0);
      chk("rst_max_score", int'(max_score), 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic run with fixed 1-cycle datapath latency and checked timing.
      sc = '{9, 7, 6, 15, 13, 17, 20, 7, 1, 2};
      go(6, 20, 1'b1, 1'b1);
      finish_run("basic");

      sc = '{default: 5};
      go(0, 5, 1'b0, 1'b1);
      finish_run("tie_all5");

      sc = '{10, 20, 30, 200, 199, 0, 150, 100, 200, 7};
      go(3, 200, 1'b0, 1'b1);
      finish_run("tie_200");

      sc = '{254, 254, 254, 254, 254, 254, 254, 254, 254, 255};
      go(9, 255, 1'b0, 1'b1);
      finish_run("last_255");

      // Random latency plus stray strobes outside WAIT.
      stray_en = 1'b1;
      for (int i = 0; i < NC; i++) lat[i] = $urandom_range(0, 7);
      sc = '{10, 50, 3, 50, 77, 77, 12, 0, 76, 5};
      repeat (4) @(negedge clk);
      go(4, 77, 1'b0, 1'b1);
      wait_valid("stray");
      repeat (3) @(negedge clk);
      stray_en = 1'b0;
      zero_lat();
      repeat (2) @(negedge clk);

      // Backpressure with start pulsed during DONE.
      ready = 1'b0;
      sc = '{10, 20, 30, 200, 199, 0, 150, 100, 200, 7};
      go(3, 200, 1'b0, 1'b1);
      wait_valid("bp");
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         @(negedge clk);
         chk("bp_valid", int'(valid), 1);
         chk("bp_max", int'(max), 3);
         chk("bp_max_score", int'(max_score), 200);
      end
      start = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      chk("bp_idle_busy", int'(busy), 0);
      chk("bp_idle_valid", int'(valid), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_no_rerun", int'(busy), 0);
      end

      // Reset asserted while waiting on idx 4.
      sc = '{9, 7, 6, 15, 13, 17, 20, 7, 1, 2};
      lat[4] = 3;
      go(0, 0, 1'b0, 1'b0);
      begin
         int n = 0;
         while (!(busy && !neuron_start && int'(neuron_sel) == 4) && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("rr_reach_wait4", int'(neuron_sel), 4);
      end
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rr_busy", int'(busy), 0);
         chk("rr_valid", int'(valid), 0);
         chk("rr_nstart", int'(neuron_start), 0);
         chk("rr_sel", int'(neuron_sel), 0);
         chk("rr_max", int'(max), 0);
         chk("rr_max_score", int'(max_score), 0);
         if (i < 2) @(negedge clk);
      end
      exp_sel = 0;
      npulse = 0;
      #1 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_post_valid", int'(valid), 0);
         chk("rr_post_busy", int'(busy), 0);
      end
      zero_lat();
      go(6, 20, 1'b0, 1'b1);
      finish_run("rr_rerun");

      // Back-to-back runs with start held high.
      sc = '{9, 7, 6, 15, 13, 17, 20, 7, 1, 2};
      begin
         exp_t e;
         int h;
         int n = 0;
         e.idx = 6; e.score = 20; e.vcyc = -1; sbq.push_back(e);
         e.idx = 2; e.score = 99; e.vcyc = -1; sbq.push_back(e);
         @(negedge clk);
         start = 1'b1;
         wait_valid("b2b_first");
         h = cyc;
         sc = '{1, 50, 99, 98, 0, 99, 3, 4, 5, 6};
         @(negedge clk);
         while (!neuron_start && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("b2b_gap", cyc, h + 2);
         start = 1'b0;
         @(negedge clk);
         chk("b2b_max_held", int'(max), 6);
         finish_run("b2b_second");
         repeat (3) @(negedge clk);
         chk("b2b_no_third", int'(busy), 0);
      end

      chk("sb_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
